key_event_decoder: RTL



---
 rtl/key_event_decoder_pkg.sv | 30 +++
 rtl/key_event_decoder_if.sv | 22 ++
 rtl/key_event_decoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/key_event_decoder_pkg.sv
// Shared constants for the push-button event decoder: state codes, 50 MHz timing
// defaults, the registered event bundle and a saturating repeat-count helper.
package key_event_decoder_pkg;

   localparam int CLK_HZ       = 50_000_000;
   localparam int TIME_20MS    = CLK_HZ / 50;
   localparam int TIME_0_5S    = CLK_HZ / 2;
   localparam int TIME_DBL_DEF = 15_000_000;

   localparam int GAP_W = 25;
   localparam int REP_W = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HELD  = 3'd1;
   localparam logic [2:0] ST_LONG  = 3'd2;
   localparam logic [2:0] ST_WAIT2 = 3'd3;
   localparam logic [2:0] ST_HELD2 = 3'd4;

   typedef struct packed {
      logic short_press;
      logic long_press;
      logic repeat_out;
      logic double_click;
   } key_evt_t;

   function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
      return (v == {REP_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Button-side inputs and classified event pulses between debounce, decoder and control logic.
// master drives the debounced key signals and observes events; slave is the decoder.
interface key_event_decoder_if;

   logic key_pulse;
   logic key_down;
   logic short_press;
   logic long_press;
   logic repeat_out;
   logic double_click;

   modport master (
      output key_pulse, key_down,
      input  short_press, long_press, repeat_out, double_click
   );

   modport slave (
      input  key_pulse, key_down,
      output short_press, long_press, repeat_out, double_click
   );

endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into short/long/repeat/double-click pulses, one cycle after
// the triggering input or gap timeout; no backpressure, each event is a single registered pulse.
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int TIME_DBL  = TIME_DBL_DEF,
   parameter int LONG_REPS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   key_event_decoder_if.slave kev
);

   localparam logic [REP_W-1:0] LONG_REPS_W = REP_W'(LONG_REPS);
   localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(TIME_DBL - 1);

   logic [2:0]       state_q, state_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   key_evt_t         evt_q, evt_d;

   logic [REP_W-1:0] rep_inc;
   logic             long_hit;
   logic             gap_done;

   assign rep_inc  = sat_inc(rep_q);
   assign long_hit = kev.key_pulse && (rep_inc == LONG_REPS_W);
   assign gap_done = (gap_q == GAP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rep_q   <= '0;
         gap_q   <= '0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         evt_q   <= evt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (kev.key_pulse) begin
               state_d = ST_HELD;
               rep_d   = REP_W'(1);
            end
         end
         ST_HELD: begin
            if (kev.key_pulse) rep_d = rep_inc;
            // A pulse coinciding with release is counted before the release is acted on.
            if (long_hit) begin
               state_d = kev.key_down ? ST_LONG : ST_IDLE;
            end else if (!kev.key_down) begin
               state_d = ST_WAIT2;
               gap_d   = '0;
            end
         end
         ST_LONG: begin
            if (!kev.key_down) state_d = ST_IDLE;
         end
         ST_WAIT2: begin
            gap_d = gap_q + 1'b1;
            if (kev.key_pulse) begin
               state_d = ST_HELD2;
               gap_d   = '0;
            end else if (gap_done) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end
         end
         ST_HELD2: begin
            if (!kev.key_down) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            rep_d   = '0;
            gap_d   = '0;
         end
      endcase
   end

   always_comb begin
      evt_d = '0;
      unique case (state_q)
         ST_HELD:  evt_d.long_press   = long_hit;
         ST_LONG:  evt_d.repeat_out   = kev.key_pulse;
         ST_WAIT2: begin
            // A second press landing on the timeout cycle is still a double click.
            evt_d.double_click = kev.key_pulse;
            evt_d.short_press  = !kev.key_pulse && gap_done;
         end
         default:  evt_d = '0;
      endcase
   end

   assign kev.short_press  = evt_q.short_press;
   assign kev.long_press   = evt_q.long_press;
   assign kev.repeat_out   = evt_q.repeat_out;
   assign kev.double_click = evt_q.double_click;

endmodule
